ahb_master: RTL and testbench

Single-transfer AMBA AHB (AHB2-style) bus master that turns one-cycle local read/write request pulses into AHB NONSEQ single word transfers. It sits between a simple local command interface and the AHB interconnect. It drives address and data phases, honours HREADY wait states, returns read data and reports error responses.

---
 rtl/ahb_master_if.sv | 35 +++
 rtl/ahb_master.sv | 99 +++++++++
 tb/tb_ahb_master.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/ahb_master_if.sv
// Bus bundle for the single-transfer AHB master: AHB master-side signals plus
// the local request/response signals it serves.
interface ahb_master_if;
    logic        HREADY;
    logic [1:0]  HRESP;
    logic [31:0] HRDATA;
    logic        request_write;
    logic        request_read;
    logic [31:0] write_data;
    logic [31:0] read_addr;
    logic [31:0] write_addr;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic [31:0] read_data;
    logic        error_flag;

    modport master (
        input  HREADY, HRESP, HRDATA,
        input  request_write, request_read, write_data, read_addr, write_addr,
        output HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS,
        output read_data, error_flag
    );

    modport slave (
        output HREADY, HRESP, HRDATA,
        output request_write, request_read, write_data, read_addr, write_addr,
        input  HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS,
        input  read_data, error_flag
    );
endinterface

// File: rtl/ahb_master.sv
// Single-transfer AHB master: one local request pulse becomes one NONSEQ SINGLE
// word transfer; wait states honoured, read data and error status returned.
module ahb_master (
    input  logic         HCLK,
    input  logic         HRESETn,
    ahb_master_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    state_t      state_q, state_d;
    logic [31:0] haddr_q, haddr_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        hwrite_q, hwrite_d;
    logic [1:0]  htrans_q, htrans_d;
    logic        err_q, err_d;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= S_IDLE;
            haddr_q  <= '0;
            hwdata_q <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            hwrite_q <= 1'b0;
            htrans_q <= TRANS_IDLE;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            haddr_q  <= haddr_d;
            hwdata_q <= hwdata_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            hwrite_q <= hwrite_d;
            htrans_q <= htrans_d;
            err_q    <= err_d;
        end
    end

    // The address phase never stretches: no earlier data phase can be pending.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.request_write || bus.request_read) state_d = S_ADDR;
            S_ADDR: state_d = S_DATA;
            S_DATA: if (bus.HREADY) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        haddr_d  = haddr_q;
        hwdata_d = hwdata_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        hwrite_d = hwrite_q;
        htrans_d = TRANS_IDLE;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.request_write) begin
                    haddr_d  = bus.write_addr;
                    wdata_d  = bus.write_data;
                    hwrite_d = 1'b1;
                    htrans_d = TRANS_NONSEQ;
                    err_d    = 1'b0;
                end else if (bus.request_read) begin
                    haddr_d  = bus.read_addr;
                    hwrite_d = 1'b0;
                    htrans_d = TRANS_NONSEQ;
                    err_d    = 1'b0;
                end
            end
            S_ADDR: begin
                if (hwrite_q) hwdata_d = wdata_q;
            end
            S_DATA: begin
                if (bus.HRESP != 2'b00) err_d = 1'b1;
                // Read data is captured even on a non-OKAY completion.
                if (bus.HREADY && !hwrite_q) rdata_d = bus.HRDATA;
            end
            default: ;
        endcase
    end

    assign bus.HADDR      = haddr_q;
    assign bus.HWDATA     = hwdata_q;
    assign bus.HWRITE     = hwrite_q;
    assign bus.HTRANS     = htrans_q;
    assign bus.HSIZE      = 3'b010;
    assign bus.HBURST     = 3'b000;
    assign bus.HPROT      = 4'b0011;
    assign bus.read_data  = rdata_q;
    assign bus.error_flag = err_q;
endmodule

// File: tb/tb_ahb_master.sv
// Self-checking bench for ahb_master: expected transfers queued at request time,
// popped and compared when the master puts the NONSEQ address phase on the bus.
module tb_ahb_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ahb_master_if bus ();
    ahb_master dut (.HCLK(clk), .HRESETn(rst_n), .bus(bus));

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] model_rd = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_haddr"},  bus.HADDR, 32'h0);
        check_val({tag, "_hwdata"}, bus.HWDATA, 32'h0);
        check_val({tag, "_hwrite"}, {31'b0, bus.HWRITE}, 32'h0);
        check_val({tag, "_htrans"}, {30'b0, bus.HTRANS}, 32'h0);
        check_val({tag, "_rdata"},  bus.read_data, 32'h0);
        check_val({tag, "_err"},    {31'b0, bus.error_flag}, 32'h0);
        check_val({tag, "_hsize"},  {29'b0, bus.HSIZE}, 32'h2);
        check_val({tag, "_hburst"}, {29'b0, bus.HBURST}, 32'h0);
        check_val({tag, "_hprot"},  {28'b0, bus.HPROT}, 32'h3);
    endtask

    // One complete transfer; called 1 time unit after a rising edge.
    task automatic xfer(input string tag, input bit do_wr, input bit do_rd,
                        input logic [31:0] waddr, input logic [31:0] raddr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int waits, input logic [1:0] resp, input bit extra);
        exp_t e;
        exp_t got;
        bit   exp_err;
        e.wr    = do_wr;
        e.addr  = do_wr ? waddr : raddr;
        e.wdata = wdata;
        exp_q.push_back(e);
        exp_err = (resp != 2'b00);

        bus.request_write = do_wr;
        bus.request_read  = do_rd;
        bus.write_addr    = waddr;
        bus.read_addr     = raddr;
        bus.write_data    = wdata;
        @(posedge clk); #1;
        bus.request_write = 1'b0;
        bus.request_read  = 1'b0;

        check_val({tag, "_nonseq"}, {30'b0, bus.HTRANS}, 32'h2);
        if (exp_q.size() == 0) begin
            check_val({tag, "_sb_empty"}, 32'h1, 32'h0);
        end else begin
            got = exp_q.pop_front();
            check_val({tag, "_haddr"},  bus.HADDR, got.addr);
            check_val({tag, "_hwrite"}, {31'b0, bus.HWRITE}, {31'b0, got.wr});
            check_val({tag, "_errclr"}, {31'b0, bus.error_flag}, 32'h0);
        end
        if (extra) begin
            bus.request_read = 1'b1;
            bus.read_addr    = 32'h7000_0000;
        end
        bus.HREADY = (waits == 0);
        bus.HRESP  = resp;
        bus.HRDATA = rdata;
        @(posedge clk); #1;
        bus.request_read = 1'b0;
        check_val({tag, "_dphase_idle"}, {30'b0, bus.HTRANS}, 32'h0);
        if (do_wr) check_val({tag, "_hwdata"}, bus.HWDATA, wdata);
        if (extra) bus.request_write = 1'b1;

        for (int i = 0; i < waits; i++) begin
            @(posedge clk); #1;
            bus.request_write = 1'b0;
            check_val({tag, "_wait_rdata_hold"}, bus.read_data, model_rd);
            check_val({tag, "_wait_idle"}, {30'b0, bus.HTRANS}, 32'h0);
            if (i == waits - 1) bus.HREADY = 1'b1;
        end

        @(posedge clk); #1;
        bus.request_write = 1'b0;
        if (!do_wr) model_rd = rdata;
        check_val({tag, "_rdata"}, bus.read_data, model_rd);
        check_val({tag, "_err"}, {31'b0, bus.error_flag}, {31'b0, exp_err});
        bus.HRESP = 2'b00;
        bus.HREADY = 1'b1;

        @(posedge clk); #1;
        check_val({tag, "_after_idle"}, {30'b0, bus.HTRANS}, 32'h0);
        check_val({tag, "_err_hold"}, {31'b0, bus.error_flag}, {31'b0, exp_err});
        check_val({tag, "_rdata_hold"}, bus.read_data, model_rd);
    endtask

    initial begin
        exp_t e;
        bus.HREADY = 1'b1;
        bus.HRESP = 2'b00;
        bus.HRDATA = '0;
        bus.request_write = 1'b0;
        bus.request_read = 1'b0;
        bus.write_data = '0;
        bus.read_addr = '0;
        bus.write_addr = '0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("post_reset_idle", {30'b0, bus.HTRANS}, 32'h0);

        xfer("write", 1, 0, 32'h4000_0000, 32'h0, 32'hA5A5_A5A5, 32'h0, 0, 2'b00, 0);
        xfer("read", 0, 1, 32'h0, 32'h4000_0004, 32'h0, 32'hDEAD_BEEF, 0, 2'b00, 0);
        xfer("wait3", 0, 1, 32'h0, 32'h4000_0008, 32'h0, 32'h1234_5678, 3, 2'b00, 0);
        xfer("err_wr", 1, 0, 32'h4000_000C, 32'h0, 32'h1111_2222, 32'h0, 0, 2'b01, 0);
        check_val("err_sticky", {31'b0, bus.error_flag}, 32'h1);
        xfer("clr_rd", 0, 1, 32'h0, 32'h4000_0010, 32'h0, 32'hCAFE_F00D, 0, 2'b00, 0);
        xfer("both", 1, 1, 32'h5000_0000, 32'h6000_0000, 32'h0000_0005, 32'hBAD0_BAD0, 1, 2'b00, 1);
        xfer("retry_rd", 0, 1, 32'h0, 32'h4000_0014, 32'h0, 32'h0BAD_F00D, 1, 2'b10, 0);
        xfer("split_wr", 1, 0, 32'h4000_0018, 32'h0, 32'h3333_4444, 32'h0, 2, 2'b11, 0);

        // Reset in the data phase of a read aborts it before read_data updates.
        e.wr = 0; e.addr = 32'h4000_0020; e.wdata = '0;
        exp_q.push_back(e);
        bus.request_read = 1'b1;
        bus.read_addr = 32'h4000_0020;
        @(posedge clk); #1;
        bus.request_read = 1'b0;
        check_val("abort_nonseq", {30'b0, bus.HTRANS}, 32'h2);
        e = exp_q.pop_front();
        check_val("abort_haddr", bus.HADDR, e.addr);
        bus.HREADY = 1'b1;
        bus.HRDATA = 32'hFFFF_0000;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("abort_async");
        @(posedge clk); #1;
        check_val("abort_rdata", bus.read_data, 32'h0);
        #2 rst_n = 1'b1;
        model_rd = '0;
        @(posedge clk); #1;
        check_val("abort_idle", {30'b0, bus.HTRANS}, 32'h0);

        xfer("post_abort", 0, 1, 32'h0, 32'h4000_0024, 32'h0, 32'h5A5A_1234, 0, 2'b00, 0);
        check_val("sb_drained", exp_q.size(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
